// File: rtl/ula_pkg.sv
// ---------------------------------------------------------------------------
// ula_pkg
// Shared definitions for the ula ALU and the ula_arbiter wrapper:
//   - ALUctl operation codes understood by ula
//   - state encoding of the arbiter FSM
//   - helper that tells whether an ALUctl code is one ula implements
// No ports (package).
// ---------------------------------------------------------------------------
package ula_pkg;

    localparam logic [3:0] ULA_AND = 4'd0;
    localparam logic [3:0] ULA_OR  = 4'd1;
    localparam logic [3:0] ULA_ADD = 4'd2;
    localparam logic [3:0] ULA_SUB = 4'd6;
    localparam logic [3:0] ULA_SLT = 4'd7;
    localparam logic [3:0] ULA_NOR = 4'd12;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } arb_state_e;

    // True for the six codes ula actually implements; anything else makes
    // ula output zero.
    function automatic logic ula_ctl_legal(input logic [3:0] ctl);
        logic legal;
        case (ctl)
            ULA_AND, ULA_OR, ULA_ADD, ULA_SUB, ULA_SLT, ULA_NOR: legal = 1'b1;
            default:                                            legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/ula.sv
// ---------------------------------------------------------------------------
// ula
// Purely combinational 32-bit ALU.
// Ports:
//   alu_ctl  in   4   operation code (see ula_pkg)
//   a, b     in   32  operands
//   alu_out  out  32  result; ADD/SUB wrap modulo 2^32, SLT is an unsigned
//                     compare, unknown codes produce 0
//   zero     out  1   high when alu_out is all zeros
// ---------------------------------------------------------------------------
module ula
    import ula_pkg::*;
(
    input  logic [3:0]  alu_ctl,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] alu_out,
    output logic        zero
);

    always_comb begin
        alu_out = '0;
        case (alu_ctl)
            ULA_AND: alu_out = a & b;
            ULA_OR:  alu_out = a | b;
            ULA_ADD: alu_out = a + b;
            ULA_SUB: alu_out = a - b;
            ULA_SLT: alu_out = (a < b) ? 32'd1 : 32'd0;
            ULA_NOR: alu_out = ~(a | b);
            default: alu_out = '0;
        endcase
    end

    assign zero = (alu_out == '0);

endmodule

// File: rtl/ula_arbiter.sv
// ---------------------------------------------------------------------------
// ula_arbiter
// Shares a single ula between two requesters. Each requester offers
// ALUctl/A/B on a valid/ready handshake; one operation is in flight at a
// time and its result comes back on a shared response channel tagged with
// the owning requester index.
//
// Parameters:
//   WIDTH  operand/result width, must stay 32 to match ula
//   FAIR   1 = round-robin on ties, 0 = requester 0 always wins ties
//
// Ports:
//   clk, rst_n                 clock (rising edge), synchronous active-low reset
//   reqN_valid/ready           request handshake for requester N (N = 0, 1)
//   reqN_ctl, reqN_a, reqN_b   ALUctl code and operands of requester N
//   rsp_valid/rsp_ready        response handshake
//   rsp_id                     requester that owns the response
//   rsp_data, rsp_zero         registered ALU result and zero flag
//   rsp_err                    illegal ALUctl flag
//
// Optional feature (macro ULA_ARB_OPCHECK_EN):
//   defined     -> an ALUctl outside the implemented set is flagged at accept
//                  and reported on rsp_err with the (zero) result
//   not defined -> rsp_err is constant 0
// ---------------------------------------------------------------------------
module ula_arbiter
    import ula_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter bit FAIR  = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [3:0]       req0_ctl,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [3:0]       req1_ctl,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_zero,
    output logic             rsp_err
);

    arb_state_e       state_q, state_d;
    logic             last_grant_q, last_grant_d;
    logic [3:0]       op_ctl_q, op_ctl_d;
    logic [WIDTH-1:0] op_a_q, op_a_d;
    logic [WIDTH-1:0] op_b_q, op_b_d;
    logic             op_id_q, op_id_d;
    logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic             rsp_zero_q, rsp_zero_d;
    logic             rsp_id_q, rsp_id_d;
`ifdef ULA_ARB_OPCHECK_EN
    logic             op_err_q, op_err_d;
    logic             rsp_err_q, rsp_err_d;
`endif

    logic             grant0, grant1;
    logic [WIDTH-1:0] alu_out;
    logic             alu_zero;

    ula u_ula (
        .alu_ctl (op_ctl_q),
        .a       (op_a_q),
        .b       (op_b_q),
        .alu_out (alu_out),
        .zero    (alu_zero)
    );

    // Grants are only offered in IDLE and never while reset is asserted, so
    // ready is low during reset even if a requester already holds valid.
    // On a tie the round-robin pointer picks the requester that was not
    // served last; fixed priority always picks requester 0.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (rst_n && (state_q == ST_IDLE)) begin
            if (req0_valid && req1_valid) begin
                if (FAIR && !last_grant_q) begin
                    grant1 = 1'b1;
                end else begin
                    grant0 = 1'b1;
                end
            end else begin
                grant0 = req0_valid;
                grant1 = req1_valid;
            end
        end
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;

    // Next-state logic: accept in IDLE, capture the ALU result in EXEC,
    // hold the response in RESP until the consumer takes it.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        op_ctl_d     = op_ctl_q;
        op_a_d       = op_a_q;
        op_b_d       = op_b_q;
        op_id_d      = op_id_q;
        rsp_data_d   = rsp_data_q;
        rsp_zero_d   = rsp_zero_q;
        rsp_id_d     = rsp_id_q;
`ifdef ULA_ARB_OPCHECK_EN
        op_err_d     = op_err_q;
        rsp_err_d    = rsp_err_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (grant0 || grant1) begin
                    op_ctl_d     = grant1 ? req1_ctl : req0_ctl;
                    op_a_d       = grant1 ? req1_a   : req0_a;
                    op_b_d       = grant1 ? req1_b   : req0_b;
                    op_id_d      = grant1;
                    last_grant_d = grant1;
`ifdef ULA_ARB_OPCHECK_EN
                    op_err_d     = !ula_ctl_legal(grant1 ? req1_ctl : req0_ctl);
`endif
                    state_d      = ST_EXEC;
                end
            end
            ST_EXEC: begin
                rsp_data_d = alu_out;
                rsp_zero_d = alu_zero;
                rsp_id_d   = op_id_q;
`ifdef ULA_ARB_OPCHECK_EN
                rsp_err_d  = op_err_q;
`endif
                state_d    = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset drops any in-flight operation and
    // points the round-robin at requester 1 so requester 0 wins the first tie.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            last_grant_q <= 1'b1;
            op_ctl_q     <= '0;
            op_a_q       <= '0;
            op_b_q       <= '0;
            op_id_q      <= 1'b0;
            rsp_data_q   <= '0;
            rsp_zero_q   <= 1'b0;
            rsp_id_q     <= 1'b0;
`ifdef ULA_ARB_OPCHECK_EN
            op_err_q     <= 1'b0;
            rsp_err_q    <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            op_ctl_q     <= op_ctl_d;
            op_a_q       <= op_a_d;
            op_b_q       <= op_b_d;
            op_id_q      <= op_id_d;
            rsp_data_q   <= rsp_data_d;
            rsp_zero_q   <= rsp_zero_d;
            rsp_id_q     <= rsp_id_d;
`ifdef ULA_ARB_OPCHECK_EN
            op_err_q     <= op_err_d;
            rsp_err_q    <= rsp_err_d;
`endif
        end
    end

    assign rsp_valid = (state_q == ST_RESP);
    assign rsp_id    = rsp_id_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_zero  = rsp_zero_q;
`ifdef ULA_ARB_OPCHECK_EN
    assign rsp_err   = rsp_err_q;
`else
    assign rsp_err   = 1'b0;
`endif

endmodule

// File: tb/tb_ula_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ula_arbiter
// Self-checking bench for ula_arbiter: a table of single operations with
// hand-computed results, a monitor-driven scoreboard that predicts every
// accepted operation, and hand-written sequences for ties, response stall
// and reset in the middle of an operation.
// ---------------------------------------------------------------------------
module tb_ula_arbiter;
    import ula_pkg::*;

    localparam int WIDTH = 32;
    localparam bit FAIR  = 1'b1;
`ifdef ULA_ARB_OPCHECK_EN
    localparam bit OPCHECK = 1'b1;
`else
    localparam bit OPCHECK = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        req0_valid, req0_ready;
    logic [3:0]  req0_ctl;
    logic [31:0] req0_a, req0_b;
    logic        req1_valid, req1_ready;
    logic [3:0]  req1_ctl;
    logic [31:0] req1_a, req1_b;
    logic        rsp_valid, rsp_ready, rsp_id, rsp_zero, rsp_err;
    logic [31:0] rsp_data;

    ula_arbiter #(.WIDTH(WIDTH), .FAIR(FAIR)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_ctl   (req0_ctl),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_ctl   (req1_ctl),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_data   (rsp_data),
        .rsp_zero   (rsp_zero),
        .rsp_err    (rsp_err)
    );

    typedef struct packed {
        logic        id;
        logic [31:0] data;
        logic        zero;
        logic        err;
    } rsp_t;

    typedef struct {
        bit          req;
        logic [3:0]  ctl;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_data;
        logic        exp_zero;
        logic        exp_err;
    } vec_t;

    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;
    rsp_t sb_q[$];
    rsp_t mon_exp;
    rsp_t last_rsp;
    int   accept_cyc = 0;
    bit   pending = 1'b0;
    bit   prev_rsp_valid = 1'b0;
    vec_t vecs[10];

    // Free-running clock and cycle counter
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Hard stop in case some sequence stalls beyond all per-wait bounds
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Reference ALU written independently from the opcode list
    function automatic logic [31:0] model_alu(input logic [3:0] ctl, input logic [31:0] a,
                                              input logic [31:0] b);
        logic [31:0] r;
        r = 32'd0;
        if (ctl == 4'd0)       r = a & b;
        else if (ctl == 4'd1)  r = a | b;
        else if (ctl == 4'd2)  r = a + b;
        else if (ctl == 4'd6)  r = a - b;
        else if (ctl == 4'd7)  r = (a < b) ? 32'd1 : 32'd0;
        else if (ctl == 4'd12) r = ~(a | b);
        return r;
    endfunction

    function automatic rsp_t model_rsp(input logic id, input logic [3:0] ctl,
                                       input logic [31:0] a, input logic [31:0] b);
        rsp_t r;
        logic known;
        known  = (ctl == 4'd0) || (ctl == 4'd1) || (ctl == 4'd2) ||
                 (ctl == 4'd6) || (ctl == 4'd7) || (ctl == 4'd12);
        r.id   = id;
        r.data = model_alu(ctl, a, b);
        r.zero = (r.data == 32'd0);
        r.err  = OPCHECK && !known;
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
        end
    endtask

    // Monitor: protocol invariants every cycle, scoreboard push on each
    // request handshake, latency and content check on each response.
    always @(negedge clk) begin
        if (!rst_n) begin
            sb_q.delete();
            pending        = 1'b0;
            prev_rsp_valid = 1'b0;
        end else begin
            checkOutput("ready_onehot", 32'(req0_ready & req1_ready), 32'd0);
            checkOutput("ready_without_valid",
                        32'((req0_ready & !req0_valid) | (req1_ready & !req1_valid)), 32'd0);
            if (rsp_valid)
                checkOutput("ready_during_resp", 32'(req0_ready | req1_ready), 32'd0);
            if (req0_valid && req0_ready) begin
                sb_q.push_back(model_rsp(1'b0, req0_ctl, req0_a, req0_b));
                accept_cyc = cyc;
                pending    = 1'b1;
            end
            if (req1_valid && req1_ready) begin
                sb_q.push_back(model_rsp(1'b1, req1_ctl, req1_a, req1_b));
                accept_cyc = cyc;
                pending    = 1'b1;
            end
            if (rsp_valid && !prev_rsp_valid && pending) begin
                checkOutput("latency", 32'(cyc - accept_cyc), 32'd2);
                pending = 1'b0;
            end
            if (rsp_valid && rsp_ready) begin
                last_rsp = '{id: rsp_id, data: rsp_data, zero: rsp_zero, err: rsp_err};
                if (sb_q.size() == 0) begin
                    checkOutput("unexpected_rsp", 32'd1, 32'd0);
                end else begin
                    mon_exp = sb_q.pop_front();
                    checkOutput("sb_id",   32'(rsp_id),   32'(mon_exp.id));
                    checkOutput("sb_data", rsp_data,      mon_exp.data);
                    checkOutput("sb_zero", 32'(rsp_zero), 32'(mon_exp.zero));
                    checkOutput("sb_err",  32'(rsp_err),  32'(mon_exp.err));
                end
            end
            prev_rsp_valid = rsp_valid;
        end
    end

    task automatic drive_req(input bit r, input logic [3:0] ctl, input logic [31:0] a,
                             input logic [31:0] b, input logic v);
        if (!r) begin
            req0_valid = v; req0_ctl = ctl; req0_a = a; req0_b = b;
        end else begin
            req1_valid = v; req1_ctl = ctl; req1_a = a; req1_b = b;
        end
    endtask

    // Waits for ready of requester r, then steps past the handshake edge
    task automatic wait_grant(input bit r);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if ((!r && req0_ready) || (r && req1_ready)) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) checkOutput("grant_timeout", 32'd1, 32'd0);
        @(posedge clk);
        #1;
    endtask

    // Waits until every predicted response has been consumed
    task automatic drain();
        for (int i = 0; i < 60 && sb_q.size() != 0; i++) @(negedge clk);
        if (sb_q.size() != 0) checkOutput("drain_timeout", 32'(sb_q.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input vec_t v);
        last_rsp = 'x;
        drive_req(v.req, v.ctl, v.a, v.b, 1'b1);
        wait_grant(v.req);
        drive_req(v.req, v.ctl, v.a, v.b, 1'b0);
        drain();
    endtask

    task automatic check_vector(input vec_t v, input int idx);
        checkOutput($sformatf("vec%0d_id", idx),   32'(last_rsp.id),   32'(v.req));
        checkOutput($sformatf("vec%0d_data", idx), last_rsp.data,      v.exp_data);
        checkOutput($sformatf("vec%0d_zero", idx), 32'(last_rsp.zero), 32'(v.exp_zero));
        checkOutput($sformatf("vec%0d_err", idx),  32'(last_rsp.err),  32'(v.exp_err));
    endtask

    task automatic check_reset_outputs(input string tag);
        checkOutput({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        checkOutput({tag, "_rsp_id"},    32'(rsp_id),    32'd0);
        checkOutput({tag, "_rsp_data"},  rsp_data,       32'd0);
        checkOutput({tag, "_rsp_zero"},  32'(rsp_zero),  32'd0);
        checkOutput({tag, "_rsp_err"},   32'(rsp_err),   32'd0);
        checkOutput({tag, "_ready"},     32'(req0_ready | req1_ready), 32'd0);
    endtask

    // Main test sequence
    initial begin
        int exp_grant[4];
        int got;

        vecs[0] = '{0, ULA_ADD, 32'd5,          32'd7,          32'd12,         1'b0, 1'b0};
        vecs[1] = '{1, ULA_ADD, 32'hFFFF_FFFF,  32'd1,          32'd0,          1'b1, 1'b0};
        vecs[2] = '{0, ULA_SUB, 32'd0,          32'd1,          32'hFFFF_FFFF,  1'b0, 1'b0};
        vecs[3] = '{1, ULA_AND, 32'hF0F0_F0F0,  32'hFF00_FF00,  32'hF000_F000,  1'b0, 1'b0};
        vecs[4] = '{0, ULA_OR,  32'h0F0F_0000,  32'h0000_00F0,  32'h0F0F_00F0,  1'b0, 1'b0};
        vecs[5] = '{1, ULA_SLT, 32'd3,          32'hFFFF_FFFF,  32'd1,          1'b0, 1'b0};
        vecs[6] = '{0, ULA_SLT, 32'hFFFF_FFFF,  32'd3,          32'd0,          1'b1, 1'b0};
        vecs[7] = '{0, ULA_NOR, 32'd0,          32'd0,          32'hFFFF_FFFF,  1'b0, 1'b0};
        vecs[8] = '{0, 4'd5,    32'd1,          32'd1,          32'd0,          1'b1, OPCHECK};
        vecs[9] = '{1, 4'd15,   32'd8,          32'd4,          32'd0,          1'b1, OPCHECK};

        // Reset with both requesters already valid: nothing may be granted
        rst_n     = 1'b0;
        rsp_ready = 1'b1;
        drive_req(0, ULA_SUB, 32'd9, 32'd9, 1'b1);
        drive_req(1, ULA_SUB, 32'd9, 32'd9, 1'b1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk);
        #1;
        drive_req(0, ULA_SUB, 32'd9, 32'd9, 1'b0);
        drive_req(1, ULA_SUB, 32'd9, 32'd9, 1'b0);
        rst_n = 1'b1;

        // Ties straight from reset: requester 0 first, then per arbitration mode
        if (FAIR) exp_grant = '{0, 1, 0, 1};
        else      exp_grant = '{0, 0, 0, 0};
        drive_req(0, ULA_SUB, 32'd9, 32'd9, 1'b1);
        drive_req(1, ULA_SUB, 32'd9, 32'd9, 1'b1);
        for (int k = 0; k < 4; k++) begin
            got = -1;
            for (int i = 0; i < 40; i++) begin
                @(negedge clk);
                if (req0_ready) begin got = 0; break; end
                if (req1_ready) begin got = 1; break; end
            end
            checkOutput($sformatf("tie_grant%0d", k), 32'(got), 32'(exp_grant[k]));
            @(posedge clk);
            #1;
        end
        drive_req(0, ULA_SUB, 32'd9, 32'd9, 1'b0);
        drive_req(1, ULA_SUB, 32'd9, 32'd9, 1'b0);
        drain();

        // Table of single operations
        for (int i = 0; i < 10; i++) begin
            applyStimulus(vecs[i]);
            check_vector(vecs[i], i);
        end

        // Response stall: result held, no new grants while the consumer waits
        rsp_ready = 1'b0;
        drive_req(1, ULA_SLT, 32'd3, 32'hFFFF_FFFF, 1'b1);
        wait_grant(1);
        drive_req(1, ULA_SLT, 32'd3, 32'hFFFF_FFFF, 1'b0);
        drive_req(0, ULA_AND, 32'h0000_00FF, 32'h0000_000F, 1'b1);
        @(negedge clk);
        checkOutput("stall_exec_valid", 32'(rsp_valid), 32'd0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput($sformatf("stall%0d_valid", i), 32'(rsp_valid), 32'd1);
            checkOutput($sformatf("stall%0d_id", i),    32'(rsp_id),    32'd1);
            checkOutput($sformatf("stall%0d_data", i),  rsp_data,       32'd1);
            checkOutput($sformatf("stall%0d_ready0", i), 32'(req0_ready), 32'd0);
        end
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        wait_grant(0);
        drive_req(0, ULA_AND, 32'h0000_00FF, 32'h0000_000F, 1'b0);
        drain();

        // Reset while the operation is in EXEC: no response may follow
        drive_req(0, ULA_ADD, 32'd40, 32'd2, 1'b1);
        wait_grant(0);
        drive_req(0, ULA_ADD, 32'd40, 32'd2, 1'b0);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        check_reset_outputs("midreset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checkOutput($sformatf("no_stale_rsp%0d", i), 32'(rsp_valid), 32'd0);
        end
        @(posedge clk);
        #1;
        applyStimulus(vecs[7]);
        check_vector(vecs[7], 7);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
